// File: rtl/reg_bank_onehot16.sv
// 16-entry register bank fed by a one-hot write-select vector, with two
// registered read ports, a sticky illegal-select flag and a sequenced bulk clear.
module reg_bank_onehot16 #(
  parameter int unsigned           DATA_W    = 16,
  parameter logic [DATA_W-1:0]     RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [15:0]       WR,
  input  logic [DATA_W-1:0] WD,
  input  logic [3:0]        RA,
  input  logic [3:0]        RB,
  input  logic              CLR,
  input  logic              ERR_CLR,
  output logic [DATA_W-1:0] DA,
  output logic [DATA_W-1:0] DB,
  output logic              BUSY,
  output logic              ERR
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [16];

  logic wr_onehot;
  logic wr_illegal;
  logic wr_valid;

  assign BUSY       = (state_q == S_CLEAR);
  assign wr_onehot  = (WR != '0) && ((WR & (WR - 16'd1)) == '0);
  assign wr_illegal = WE && !wr_onehot;
  // Legal selects arriving during a clear are dropped, so bypass is also off then.
  assign wr_valid   = WE && wr_onehot && !BUSY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (CLR) state_d = S_CLEAR;
      S_CLEAR: if (cnt == 4'd15) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      cnt     <= (state_q == S_CLEAR) ? cnt + 4'd1 : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= RESET_VAL;
    end else if (state_q == S_CLEAR) begin
      mem[cnt] <= RESET_VAL;
    end else if (wr_valid) begin
      for (int unsigned i = 0; i < 16; i++)
        if (WR[i]) mem[i] <= WD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DA <= '0;
      DB <= '0;
    end else begin
      DA <= (wr_valid && WR[RA]) ? WD : mem[RA];
      DB <= (wr_valid && WR[RB]) ? WD : mem[RB];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      ERR <= 1'b0;
    else if (wr_illegal)
      ERR <= 1'b1;
    else if (ERR_CLR)
      ERR <= 1'b0;
  end

endmodule
